// File: rtl/instr_sequencer.sv
// Micro-state sequencer and instruction register for the multicycle 8-bit CPU.
// Every state or IR update is gated by cycleEn, which requires memory readiness and the step enable.
module instr_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int INSTR_WIDTH  = 16,
  parameter int OPCODE_WIDTH = 4,
  parameter int FUNC_WIDTH   = 4,
  parameter int STATE_WIDTH  = 3,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stepEn,
  input  logic                    memAccess,
  input  logic                    memReady,
  input  logic [DATA_WIDTH-1:0]   memReadData,
  input  logic                    resetState,
  input  logic                    instrRegLowWriteEn,
  input  logic                    instrRegHighWriteEn,
  output logic [STATE_WIDTH-1:0]  state,
  output logic [INSTR_WIDTH-1:0]  instr,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [FUNC_WIDTH-1:0]   func,
  output logic                    cycleEn,
  output logic                    instrValid,
  output logic                    retire,
  output logic [COUNT_WIDTH-1:0]  retireCount,
  output logic                    seqFault
);

  logic [STATE_WIDTH-1:0] r_state;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_instr_valid;
  logic [COUNT_WIDTH-1:0] r_retire_count;
  logic                   r_seq_fault;
  logic                   w_cycle_en;
  logic                   w_retire;
  logic                   w_state_last;

  assign w_cycle_en   = stepEn & (~memAccess | memReady);
  assign w_retire     = w_cycle_en & resetState;
  assign w_state_last = (r_state == {STATE_WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= '0;
      r_instr        <= '0;
      r_instr_valid  <= 1'b0;
      r_retire_count <= '0;
      r_seq_fault    <= 1'b0;
    end else if (w_cycle_en) begin
      // Running past the last state without resetState means the decoder lost track.
      if (resetState) begin
        r_state <= '0;
      end else if (w_state_last) begin
        r_state     <= '0;
        r_seq_fault <= 1'b1;
      end else begin
        r_state <= r_state + 1'b1;
      end

      // High-byte load comes last so that a simultaneous dual load leaves instrValid set.
      if (instrRegLowWriteEn) begin
        r_instr[DATA_WIDTH-1:0] <= memReadData;
        r_instr_valid           <= 1'b0;
      end
      if (instrRegHighWriteEn) begin
        r_instr[INSTR_WIDTH-1:DATA_WIDTH] <= memReadData;
        r_instr_valid                     <= 1'b1;
      end

      if (resetState) begin
        r_retire_count <= r_retire_count + 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign instr       = r_instr;
  assign opcode      = r_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign func        = r_instr[FUNC_WIDTH-1:0];
  assign cycleEn     = w_cycle_en;
  assign instrValid  = r_instr_valid;
  assign retire      = w_retire;
  assign retireCount = r_retire_count;
  assign seqFault    = r_seq_fault;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed-vector bench for instr_sequencer: fetch, stalls, retire, overrun, wrap, freeze, reset.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stepEn;
  logic        memAccess;
  logic        memReady;
  logic [7:0]  memReadData;
  logic        resetState;
  logic        instrRegLowWriteEn;
  logic        instrRegHighWriteEn;
  logic [2:0]  state;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [3:0]  func;
  logic        cycleEn;
  logic        instrValid;
  logic        retire;
  logic [7:0]  retireCount;
  logic        seqFault;

  int n_checks = 0;
  int n_fails  = 0;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .stepEn(stepEn), .memAccess(memAccess), .memReady(memReady),
    .memReadData(memReadData), .resetState(resetState),
    .instrRegLowWriteEn(instrRegLowWriteEn), .instrRegHighWriteEn(instrRegHighWriteEn),
    .state(state), .instr(instr), .opcode(opcode), .func(func), .cycleEn(cycleEn),
    .instrValid(instrValid), .retire(retire), .retireCount(retireCount), .seqFault(seqFault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stepEn = 1'b1; memAccess = 1'b0; memReady = 1'b1; memReadData = 8'h00;
    resetState = 1'b0; instrRegLowWriteEn = 1'b0; instrRegHighWriteEn = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++; if (cycleEn !== 1'b1) begin n_fails++; $display("FAIL reset_cycleEn_comb: got %b want 1", cycleEn); end
    tick();
    reset = 1'b0;
    n_checks++; if (state !== 3'd0) begin n_fails++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (instr !== 16'h0000) begin n_fails++; $display("FAIL reset_instr: got %h want 0000", instr); end
    n_checks++; if (opcode !== 4'h0 || func !== 4'h0) begin n_fails++; $display("FAIL reset_fields: got op=%h func=%h want 0/0", opcode, func); end
    n_checks++; if (instrValid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", instrValid); end
    n_checks++; if (retireCount !== 8'd0) begin n_fails++; $display("FAIL reset_count: got %0d want 0", retireCount); end
    n_checks++; if (seqFault !== 1'b0) begin n_fails++; $display("FAIL reset_fault: got %b want 0", seqFault); end
  endtask

  task automatic test_fetch();
    do_reset();
    memAccess = 1'b1; memReady = 1'b1;
    instrRegLowWriteEn = 1'b1; memReadData = 8'h34;
    #1;
    n_checks++; if (cycleEn !== 1'b1) begin n_fails++; $display("FAIL fetch_cycleEn: got %b want 1", cycleEn); end
    tick();
    n_checks++; if (state !== 3'd1 || instr !== 16'h0034 || instrValid !== 1'b0) begin n_fails++;
      $display("FAIL fetch_low: got state=%0d instr=%h valid=%b want 1/0034/0", state, instr, instrValid); end
    instrRegLowWriteEn = 1'b0; instrRegHighWriteEn = 1'b1; memReadData = 8'h12;
    tick();
    instrRegHighWriteEn = 1'b0;
    n_checks++; if (instr !== 16'h1234) begin n_fails++; $display("FAIL fetch_instr: got %h want 1234", instr); end
    n_checks++; if (opcode !== 4'h1 || func !== 4'h4) begin n_fails++; $display("FAIL fetch_fields: got op=%h func=%h want 1/4", opcode, func); end
    n_checks++; if (state !== 3'd2 || instrValid !== 1'b1) begin n_fails++;
      $display("FAIL fetch_high: got state=%0d valid=%b want 2/1", state, instrValid); end
  endtask

  // Continues from the fetch state: retire, refetch low byte, stall on the high byte.
  task automatic test_stall();
    memAccess = 1'b0; resetState = 1'b1;
    tick();
    resetState = 1'b0;
    n_checks++; if (state !== 3'd0 || retireCount !== 8'd1) begin n_fails++;
      $display("FAIL stall_pre_retire: got state=%0d count=%0d want 0/1", state, retireCount); end
    memAccess = 1'b1; memReady = 1'b1; instrRegLowWriteEn = 1'b1; memReadData = 8'h78;
    tick();
    instrRegLowWriteEn = 1'b0;
    n_checks++; if (instr !== 16'h1278 || instrValid !== 1'b0) begin n_fails++;
      $display("FAIL stall_low_clears_valid: got instr=%h valid=%b want 1278/0", instr, instrValid); end
    instrRegHighWriteEn = 1'b1; memReady = 1'b0; memReadData = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (cycleEn !== 1'b0) begin n_fails++; $display("FAIL stall_cycleEn[%0d]: got %b want 0", i, cycleEn); end
      tick();
      n_checks++; if (state !== 3'd1 || instr !== 16'h1278) begin n_fails++;
        $display("FAIL stall_hold[%0d]: got state=%0d instr=%h want 1/1278", i, state, instr); end
    end
    memReady = 1'b1; memReadData = 8'hAB;
    tick();
    instrRegHighWriteEn = 1'b0;
    n_checks++; if (state !== 3'd2 || instr !== 16'hAB78 || instrValid !== 1'b1) begin n_fails++;
      $display("FAIL stall_commit: got state=%0d instr=%h valid=%b want 2/ab78/1", state, instr, instrValid); end
  endtask

  task automatic test_retire();
    do_reset();
    for (int s = 0; s <= 4; s++) begin
      resetState = (s == 4);
      #1;
      n_checks++; if (state !== 3'(s) || retire !== (s == 4)) begin n_fails++;
        $display("FAIL retire_seq[%0d]: got state=%0d retire=%b want %0d/%b", s, state, retire, s, (s == 4)); end
      tick();
    end
    resetState = 1'b0;
    n_checks++; if (state !== 3'd0 || retireCount !== 8'd1 || seqFault !== 1'b0) begin n_fails++;
      $display("FAIL retire_end: got state=%0d count=%0d fault=%b want 0/1/0", state, retireCount, seqFault); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int s = 0; s <= 7; s++) begin
      #1;
      n_checks++; if (state !== 3'(s) || retire !== 1'b0 || seqFault !== 1'b0) begin n_fails++;
        $display("FAIL overrun_seq[%0d]: got state=%0d retire=%b fault=%b want %0d/0/0", s, state, retire, seqFault, s); end
      tick();
    end
    n_checks++; if (state !== 3'd0 || seqFault !== 1'b1 || retireCount !== 8'd0) begin n_fails++;
      $display("FAIL overrun_fault: got state=%0d fault=%b count=%0d want 0/1/0", state, seqFault, retireCount); end
    resetState = 1'b1; tick(); resetState = 1'b0; tick(); tick();
    n_checks++; if (seqFault !== 1'b1 || state !== 3'd2) begin n_fails++;
      $display("FAIL overrun_sticky: got fault=%b state=%0d want 1/2", seqFault, state); end
    do_reset();
    n_checks++; if (seqFault !== 1'b0) begin n_fails++; $display("FAIL overrun_clear: got %b want 0", seqFault); end
  endtask

  task automatic test_wrap_freeze();
    do_reset();
    resetState = 1'b1;
    repeat (255) tick();
    n_checks++; if (retireCount !== 8'd255 || state !== 3'd0) begin n_fails++;
      $display("FAIL wrap_preload: got count=%0d state=%0d want 255/0", retireCount, state); end
    tick();
    n_checks++; if (retireCount !== 8'd0) begin n_fails++; $display("FAIL wrap_zero: got %0d want 0", retireCount); end
    resetState = 1'b0; instrRegLowWriteEn = 1'b1; memReadData = 8'h5A;
    tick();
    instrRegLowWriteEn = 1'b0; instrRegHighWriteEn = 1'b1; memReadData = 8'hC3;
    tick();
    stepEn = 1'b0; resetState = 1'b1; memAccess = 1'b1; memReady = 1'b1;
    instrRegLowWriteEn = 1'b1; instrRegHighWriteEn = 1'b1; memReadData = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (cycleEn !== 1'b0 || retire !== 1'b0) begin n_fails++;
        $display("FAIL freeze_strobes[%0d]: got cycleEn=%b retire=%b want 0/0", i, cycleEn, retire); end
      tick();
      n_checks++; if (state !== 3'd2 || instr !== 16'hC35A || instrValid !== 1'b1 || retireCount !== 8'd0 || seqFault !== 1'b0) begin
        n_fails++;
        $display("FAIL freeze_hold[%0d]: got state=%0d instr=%h valid=%b count=%0d fault=%b want 2/c35a/1/0/0",
                 i, state, instr, instrValid, retireCount, seqFault); end
    end
    stepEn = 1'b1;
    tick();
    n_checks++; if (instr !== 16'hEEEE || instrValid !== 1'b1 || state !== 3'd0 || retireCount !== 8'd1) begin n_fails++;
      $display("FAIL dual_load: got instr=%h valid=%b state=%0d count=%0d want eeee/1/0/1", instr, instrValid, state, retireCount); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    resetState = 1'b1; tick(); resetState = 1'b0;
    instrRegLowWriteEn = 1'b1; memReadData = 8'h11; tick();
    instrRegLowWriteEn = 1'b0; instrRegHighWriteEn = 1'b1; memReadData = 8'h22; tick();
    instrRegHighWriteEn = 1'b0; tick();
    n_checks++; if (state !== 3'd3 || instr !== 16'h2211 || retireCount !== 8'd1) begin n_fails++;
      $display("FAIL mid_setup: got state=%0d instr=%h count=%0d want 3/2211/1", state, instr, retireCount); end
    memAccess = 1'b1; memReady = 1'b0; reset = 1'b1; resetState = 1'b1; instrRegHighWriteEn = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (state !== 3'd0 || instr !== 16'h0000 || instrValid !== 1'b0 || seqFault !== 1'b0 || retireCount !== 8'd0) begin
      n_fails++;
      $display("FAIL mid_reset: got state=%0d instr=%h valid=%b fault=%b count=%0d want 0/0000/0/0/0",
               state, instr, instrValid, seqFault, retireCount); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_stall();
    test_retire();
    test_overrun();
    test_wrap_freeze();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Sits directly upstream of the main decoder in the multicycle 8-bit CPU.
- Owns the 3-bit micro-state counter and the 16-bit instruction register, and drives `state`, `opcode` and `func` into the decoder.
- Consumes the decoder's `resetState`, `instrRegLowWriteEn` and `instrRegHighWriteEn`.
- Gates every state advance on memory readiness and a step/run enable, and produces the `cycleEn` strobe that the datapath ANDs with all of its write enables.

Parameters:
- DATA_WIDTH, 8, memory data byte width.
- INSTR_WIDTH, 16, instruction register width (2*DATA_WIDTH).
- OPCODE_WIDTH, 4, opcode field width.
- FUNC_WIDTH, 4, func field width.
- STATE_WIDTH, 3, micro-state counter width.
- COUNT_WIDTH, 8, retired-instruction counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stepEn  input  1  run/step enable; 0 freezes the sequencer.
- memAccess  input  1  current micro-state performs a memory read or write.
- memReady  input  1  memory has completed the current access this cycle.
- memReadData  input  DATA_WIDTH  byte returned by memory.
- resetState  input  1  from decoder: current instruction finishes in this state.
- instrRegLowWriteEn  input  1  from decoder: load IR low byte.
- instrRegHighWriteEn  input  1  from decoder: load IR high byte.
- state  output  STATE_WIDTH  current micro-state, to decoder.
- instr  output  INSTR_WIDTH  full instruction register (immediates, register indices).
- opcode  output  OPCODE_WIDTH  instr[15:12].
- func  output  FUNC_WIDTH  instr[3:0].
- cycleEn  output  1  combinational; this cycle commits.
- instrValid  output  1  IR holds a complete instruction.
- retire  output  1  combinational; instruction completes this cycle.
- retireCount  output  COUNT_WIDTH  retired instructions, wraps.
- seqFault  output  1  sticky; state overran without resetState.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state=0, instr=0, instrValid=0, retireCount=0, seqFault=0. Consequently opcode=0 and func=0. cycleEn and retire are combinational, so they follow their equations during reset.
- Reset wins over every other event in the same cycle, including mid-instruction (any state, any pending memory wait).
- cycleEn = stepEn & (~memAccess | memReady). When cycleEn=0, all registers hold.
- State transition on cycleEn=1:
  - resetState=1: next state=0.
  - else state<7: next state=state+1.
  - else (state=7, resetState=0): next state=0 and seqFault<=1. seqFault stays set until reset.
- IR low: on cycleEn & instrRegLowWriteEn, instr[7:0] <= memReadData and instrValid<=0.
- IR high: on cycleEn & instrRegHighWriteEn, instr[15:8] <= memReadData and instrValid<=1.
- Both IR enables in the same cycle: both bytes load memReadData, instrValid<=1.
- Write enables are ignored when cycleEn=0. A stalled fetch never corrupts the IR.
- Latency: a byte loaded at edge N is visible on instr/opcode/func after edge N. The decoder therefore sees the new opcode from state 2 onward with no bubble.
- Fetch order: state 0 loads the low byte, state 1 loads the high byte. instrValid deasserts after the state-0 commit and reasserts after the state-1 commit.
- retire = cycleEn & resetState. On retire, retireCount <= retireCount+1, modulo 2^COUNT_WIDTH (255 -> 0).
- An overrun fault does not count as retire.
- Memory stall: memAccess=1 & memReady=0 holds state and the IR for any number of cycles. The commit occurs in the first cycle with memReady=1.
- stepEn=0 with memReady=1: no commit. The memory handshake is re-presented when stepEn returns.

Test Plan:
- Reset then fetch: reset 1 cycle, stepEn=1, memAccess=1, memReady=1; state0 low-en with data 0x34, state1 high-en with data 0x12 -> instr=0x1234, opcode=0x1, func=0x4, state=2, instrValid=1 after the second edge.
- Memory stall: in state 1, memReady=0 for 3 cycles with memReadData=0xFF, then 1 with 0xAB -> state stays 1 and instr[15:8] unchanged for 3 cycles; then instr[15:8]=0xAB and state=2.
- Multi-state retire: resetState asserted only in state 4 -> state sequence 0,1,2,3,4,0; retire high exactly one cycle; retireCount 0->1.
- Overrun: resetState never asserted, memAccess=0 -> state runs 0..7 then 0; seqFault=1 from the following cycle; retireCount unchanged; seqFault persists until reset.
- Counter wrap and freeze: preload 255 retires, then retire once -> retireCount=0. stepEn=0 for 5 cycles with resetState=1 -> no change to any register.
- Reset mid-instruction: reset at state 3 with memReady=0 -> next cycle state=0, instr=0, instrValid=0, seqFault=0, retireCount=0.
